// File: rtl/region_profiler.sv
// region_profiler
//   Per-frame ink-density profiler for the six character windows of the
//   segmentation datapath. Counts dark pixels (R+G+B nibble sum below
//   DARK_THRESH) inside each window during a frame, snapshots the six counts
//   at frame end and drains them one entry per handshake.
//
// Parameters
//   DARK_THRESH  luma threshold; pixel is dark when R+G+B < DARK_THRESH
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   pix_en       pixel strobe qualifying hcnt, vcnt and pixel_in
//   hcnt, vcnt   shared VGA horizontal / vertical counters
//   pixel_in     gated pixel from segment, {R[11:8], G[7:4], B[3:0]}
//   out_valid    snapshot entry available
//   out_ready    consumer accepts the current entry
//   out_region   window index of the current entry (0..5)
//   out_count    dark-pixel count of out_region
//   out_last     high with region 5
//   frame_drop   one-cycle pulse when a frame ends while still draining
module region_profiler #(
   parameter int unsigned DARK_THRESH = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [9:0]  hcnt,
   input  logic [9:0]  vcnt,
   input  logic [11:0] pixel_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_region,
   output logic [13:0] out_count,
   output logic        out_last,
   output logic        frame_drop
);

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_DRAIN = 1'b1;

   localparam logic [6:0] THRESH = 7'(DARK_THRESH);

   logic        state;
   logic [2:0]  index;
   logic [13:0] acc  [6];
   logic [13:0] snap [6];

   logic [5:0]  lum;
   logic        isDark;
   logic        inRows;
   logic [5:0]  winHit;
   logic        frameEnd;
   logic [13:0] nextCount;

   always_comb begin
      lum = {2'b00, pixel_in[11:8]} + {2'b00, pixel_in[7:4]} + {2'b00, pixel_in[3:0]};
      isDark = ({1'b0, lum} < THRESH);
   end

   always_comb begin
      inRows = (vcnt >= 10'd151) && (vcnt <= 10'd299);
      winHit = '0;
      if (inRows) begin
         winHit[0] = (hcnt >= 10'd51)  && (hcnt <= 10'd124);
         winHit[1] = (hcnt >= 10'd141) && (hcnt <= 10'd214);
         winHit[2] = (hcnt >= 10'd231) && (hcnt <= 10'd304);
         winHit[3] = (hcnt >= 10'd336) && (hcnt <= 10'd409);
         winHit[4] = (hcnt >= 10'd426) && (hcnt <= 10'd499);
         winHit[5] = (hcnt >= 10'd516) && (hcnt <= 10'd589);
      end
   end

   assign frameEnd = pix_en && (vcnt == 10'd300) && (hcnt == '0);

   // Count of the entry that follows the current one, so the output
   // registers can be loaded at the accepting edge.
   always_comb begin
      nextCount = '0;
      case (index)
         3'd0:    nextCount = snap[1];
         3'd1:    nextCount = snap[2];
         3'd2:    nextCount = snap[3];
         3'd3:    nextCount = snap[4];
         3'd4:    nextCount = snap[5];
         default: nextCount = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= STATE_IDLE;
         index      <= '0;
         out_valid  <= 1'b0;
         out_region <= '0;
         out_count  <= '0;
         out_last   <= 1'b0;
         frame_drop <= 1'b0;
         for (int unsigned k = 0; k < 6; k++) begin
            acc[k]  <= '0;
            snap[k] <= '0;
         end
      end else begin
         frame_drop <= frameEnd && (state == STATE_DRAIN);

         // Row 300 lies outside every window, so clearing on frame end
         // never competes with an increment.
         for (int unsigned k = 0; k < 6; k++) begin
            if (frameEnd) begin
               acc[k] <= '0;
            end else if (pix_en && isDark && winHit[k]) begin
               acc[k] <= acc[k] + 14'd1;
            end
         end

         case (state)
            STATE_IDLE: begin
               if (frameEnd) begin
                  for (int unsigned k = 0; k < 6; k++) begin
                     snap[k] <= acc[k];
                  end
                  index      <= '0;
                  state      <= STATE_DRAIN;
                  out_valid  <= 1'b1;
                  out_region <= '0;
                  out_count  <= acc[0];
                  out_last   <= 1'b0;
               end
            end
            STATE_DRAIN: begin
               if (out_ready) begin
                  if (index == 3'd5) begin
                     state      <= STATE_IDLE;
                     index      <= '0;
                     out_valid  <= 1'b0;
                     out_region <= '0;
                     out_count  <= '0;
                     out_last   <= 1'b0;
                  end else begin
                     index      <= index + 3'd1;
                     out_region <= index + 3'd1;
                     out_count  <= nextCount;
                     out_last   <= (index == 3'd4);
                  end
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_region_profiler.sv
// tb_region_profiler
//   Self-checking bench for region_profiler. Two instances (thresholds 24
//   and 25) see identical stimulus. A behavioural model accumulates expected
//   per-window counts as pixels are driven; at each frame end the expected
//   six entries are queued and a monitor compares every presented entry
//   against the queue head, popping it on handshake.
module tb_region_profiler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic [9:0]  hcnt = '0;
   logic [9:0]  vcnt = '0;
   logic [11:0] pixel_in = '0;
   logic        out_ready = 1'b0;

   logic        outValid, outLast, frameDrop;
   logic [2:0]  outRegion;
   logic [13:0] outCount;
   logic        outValid25, outLast25, frameDrop25;
   logic [2:0]  outRegion25;
   logic [13:0] outCount25;

   region_profiler #(.DARK_THRESH(24)) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .pixel_in(pixel_in), .out_valid(outValid), .out_ready(out_ready),
      .out_region(outRegion), .out_count(outCount), .out_last(outLast),
      .frame_drop(frameDrop)
   );

   region_profiler #(.DARK_THRESH(25)) dut25 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .pixel_in(pixel_in), .out_valid(outValid25), .out_ready(out_ready),
      .out_region(outRegion25), .out_count(outCount25), .out_last(outLast25),
      .frame_drop(frameDrop25)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  region;
      logic [13:0] cnt24;
      logic [13:0] cnt25;
      logic        last;
   } entry_t;

   entry_t      expQ[$];
   entry_t      monE;
   int          compared = 0;
   int          mismatched = 0;
   int          expDrops = 0;
   int          dropsSeen = 0;
   int          drops25Seen = 0;
   int unsigned modelAcc24[6];
   int unsigned modelAcc25[6];
   int unsigned winLo[6] = '{51, 141, 231, 336, 426, 516};

   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int windowOf(input int h, input int v);
      if (v < 151 || v > 299) return -1;
      for (int k = 0; k < 6; k++) begin
         if (h >= int'(winLo[k]) && h < int'(winLo[k]) + 74) return k;
      end
      return -1;
   endfunction

   task automatic clearModel();
      for (int k = 0; k < 6; k++) begin
         modelAcc24[k] = 0;
         modelAcc25[k] = 0;
      end
   endtask

   // Drive one pixel for one clock edge and update the model.
   task automatic drivePixel(input int h, input int v, input logic [11:0] p, input logic en);
      int w;
      int lum;
      hcnt = 10'(h);
      vcnt = 10'(v);
      pixel_in = p;
      pix_en = en;
      if (en) begin
         w = windowOf(h, v);
         lum = int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
         if (w >= 0) begin
            if (lum < 24) modelAcc24[w]++;
            if (lum < 25) modelAcc25[w]++;
         end
      end
      @(posedge clk);
      #1;
      pix_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frameEndPixel(input bit expectDrop);
      entry_t e;
      bit wasIdle;
      wasIdle = (expQ.size() == 0);
      if (expectDrop) begin
         expDrops++;
      end else begin
         for (int k = 0; k < 6; k++) begin
            e.region = 3'(k);
            e.cnt24  = 14'(modelAcc24[k]);
            e.cnt25  = 14'(modelAcc25[k]);
            e.last   = (k == 5);
            expQ.push_back(e);
         end
      end
      clearModel();
      drivePixel(0, 300, 12'h000, 1'b1);
      if (!expectDrop && wasIdle) begin
         checkValue("validAfterFrameEnd", 32'(outValid), 1);
         checkValue("regionAfterFrameEnd", 32'(outRegion), 0);
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (expQ.size() != 0) begin
         checkValue("drainTimeout", 32'(expQ.size()), 0);
         expQ.delete();
      end
      idle(1);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (frameDrop) dropsSeen++;
         if (frameDrop25) drops25Seen++;
         if (outValid) begin
            checkValue("valid25", 32'(outValid25), 1);
            if (expQ.size() == 0) begin
               checkValue("unexpectedEntryQueueDepth", 0, 1);
            end else begin
               monE = expQ[0];
               checkValue("region", 32'(outRegion), 32'(monE.region));
               checkValue("count", 32'(outCount), 32'(monE.cnt24));
               checkValue("last", 32'(outLast), 32'(monE.last));
               checkValue("region25", 32'(outRegion25), 32'(monE.region));
               checkValue("count25", 32'(outCount25), 32'(monE.cnt25));
               checkValue("last25", 32'(outLast25), 32'(monE.last));
               if (out_ready) void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h;
      int v;
      bit found;
      clearModel();

      // Reset state.
      #3;
      checkValue("rstValid", 32'(outValid), 0);
      checkValue("rstRegion", 32'(outRegion), 0);
      checkValue("rstCount", 32'(outCount), 0);
      checkValue("rstLast", 32'(outLast), 0);
      checkValue("rstDrop", 32'(frameDrop), 0);
      #4 rst = 1'b0;
      idle(2);

      // Dark frame: window 5 fully dark (maximum count), windows 0..4 dark
      // on the first and last rows including one pixel either side.
      out_ready = 1'b1;
      for (v = 151; v <= 299; v++)
         for (h = 516; h <= 589; h++)
            drivePixel(h, v, 12'h000, 1'b1);
      for (int w = 0; w < 5; w++) begin
         for (h = int'(winLo[w]) - 1; h <= int'(winLo[w]) + 74; h++) begin
            drivePixel(h, 151, 12'h000, 1'b1);
            drivePixel(h, 299, 12'h000, 1'b1);
         end
      end
      frameEndPixel(0);
      waitDrain(50);
      checkValue("noDropDarkFrame", 32'(dropsSeen), 0);

      // Threshold boundary: window 2 at lum 24, others at lum 21.
      for (v = 151; v <= 155; v++)
         for (int w = 0; w < 6; w++)
            for (h = int'(winLo[w]); h < int'(winLo[w]) + 74; h++)
               drivePixel(h, v, (w == 2) ? 12'h888 : 12'h777, 1'b1);
      frameEndPixel(0);
      waitDrain(50);

      // Edges and off-window pixels.
      drivePixel(50, 151, 12'h000, 1'b1);
      drivePixel(51, 151, 12'h000, 1'b1);
      drivePixel(124, 151, 12'h000, 1'b1);
      drivePixel(125, 151, 12'h000, 1'b1);
      for (h = 51; h <= 124; h++) drivePixel(h, 150, 12'h000, 1'b1);
      for (h = 1; h <= 600; h += 7) drivePixel(h, 300, 12'h000, 1'b1);
      for (h = 141; h <= 214; h++) drivePixel(h, 200, 12'h000, 1'b0);
      for (h = 231; h <= 304; h++) drivePixel(h, 200, 12'hFFF, 1'b1);
      frameEndPixel(0);
      waitDrain(50);

      // Random pixels, strobe and positions around the windows.
      for (int i = 0; i < 3000; i++) begin
         h = int'($urandom_range(30, 620));
         v = int'($urandom_range(140, 310));
         if (v == 300 && h == 0) h = 1;
         drivePixel(h, v, 12'($urandom), ($urandom_range(0, 3) != 0));
      end
      frameEndPixel(0);
      waitDrain(50);

      // Backpressure: hold 10 cycles, then toggle ready every cycle.
      for (int w = 0; w < 6; w++)
         for (h = int'(winLo[w]); h < int'(winLo[w]) + 5 * (w + 1); h++)
            drivePixel(h, 200, 12'h123, 1'b1);
      out_ready = 1'b0;
      frameEndPixel(0);
      idle(10);
      checkValue("heldValid", 32'(outValid), 1);
      checkValue("heldQueueDepth", 32'(expQ.size()), 6);
      for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
         out_ready = ~out_ready;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      waitDrain(20);

      // Overrun: second frame ends while the first is still held.
      out_ready = 1'b0;
      for (int w = 0; w < 6; w++)
         for (h = int'(winLo[w]); h <= int'(winLo[w]) + 10 * w; h++)
            drivePixel(h, 180, 12'h001, 1'b1);
      frameEndPixel(0);
      for (int w = 0; w < 6; w++)
         for (h = int'(winLo[w]); h < int'(winLo[w]) + 74; h++)
            drivePixel(h, 190, 12'h000, 1'b1);
      frameEndPixel(1);
      idle(3);
      checkValue("dropPulse", 32'(dropsSeen), 1);
      checkValue("dropPulse25", 32'(drops25Seen), 1);
      out_ready = 1'b1;
      waitDrain(20);
      for (int w = 0; w < 6; w++)
         for (h = int'(winLo[w]) + w; h < int'(winLo[w]) + 30; h++)
            drivePixel(h, 210, 12'h100, 1'b1);
      frameEndPixel(0);
      waitDrain(20);

      // Reset after region 2 has been accepted.
      for (int w = 0; w < 6; w++)
         for (h = int'(winLo[w]); h < int'(winLo[w]) + 20; h++)
            drivePixel(h, 220, 12'h000, 1'b1);
      out_ready = 1'b1;
      frameEndPixel(0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (outValid && outRegion == 3'd3) found = 1;
         else idle(1);
      end
      checkValue("reachedRegion3", 32'(found), 1);
      #1 rst = 1'b1;
      #1;
      checkValue("midRstValid", 32'(outValid), 0);
      checkValue("midRstRegion", 32'(outRegion), 0);
      checkValue("midRstCount", 32'(outCount), 0);
      checkValue("midRstLast", 32'(outLast), 0);
      checkValue("midRstDrop", 32'(frameDrop), 0);
      checkValue("midRstValid25", 32'(outValid25), 0);
      expQ.delete();
      clearModel();
      #2 rst = 1'b0;
      idle(2);
      for (v = 230; v <= 232; v++)
         for (int w = 0; w < 6; w++)
            for (h = int'(winLo[w]); h < int'(winLo[w]) + 74; h += 2)
               drivePixel(h, v, 12'h345, 1'b1);
      frameEndPixel(0);
      waitDrain(20);

      checkValue("finalDrops", 32'(dropsSeen), 32'(expDrops));
      checkValue("finalDrops25", 32'(drops25Seen), 32'(expDrops));
      checkValue("finalQueueEmpty", 32'(expQ.size()), 0);
      checkValue("finalIdle", 32'(outValid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/region_profiler.md
# region_profiler

Per-frame ink-density profiler for the six character windows of the segmentation datapath. It sits directly downstream of the `segment` stage and consumes its gated pixel stream plus the shared VGA counters. Per frame it counts the "dark" pixels inside each of the six windows, then snapshots the six counts at frame end. The counts are drained one per handshake to the recognition logic.

## Interface

- `DARK_THRESH`, default 24: a pixel is dark when R+G+B nibble sum < `DARK_THRESH`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pix_en` in 1: pixel strobe; one pulse per pixel, qualifies `hcnt`, `vcnt` and `pixel_in`.
- `hcnt` in 10: VGA horizontal count.
- `vcnt` in 10: VGA vertical count.
- `pixel_in` in 12: pixel from `segment` as {R[11:8], G[7:4], B[3:0]}.
- `out_valid` out 1: snapshot entry available.
- `out_ready` in 1: consumer accepts the entry.
- `out_region` out 3: window index of the current entry, 0..5.
- `out_count` out 14: dark-pixel count for `out_region`.
- `out_last` out 1: high with region 5.
- `frame_drop` out 1: one-cycle pulse when a frame's counts are discarded.

## Operation

- **Windows.** All bounds are inclusive, and `vcnt` must be in 151..299 for every window.
  - Window 0: `hcnt` 51..124
  - Window 1: `hcnt` 141..214
  - Window 2: `hcnt` 231..304
  - Window 3: `hcnt` 336..409
  - Window 4: `hcnt` 426..499
  - Window 5: `hcnt` 516..589
  - Outside all windows: no count.
- **Luma.**
  - lum = R + G + B, zero-extended to 6 bits (range 0..45).
  - A pixel is dark iff lum < `DARK_THRESH`.
- **Accumulate.** On `pix_en` with the position inside window k and the pixel dark: `acc[k] <= acc[k] + 1`.
  - Width is 14 bits. The maximum count is 74×149 = 11026, so overflow is impossible; no saturation logic.
- **Frame end** is `pix_en` && `vcnt == 300` && `hcnt == 0`. It is evaluated in every state.
  - **State IDLE:** `snap[0..5] <= acc[0..5]`, `acc <= 0`, index <= 0, go to DRAIN.
  - **State DRAIN:** `acc <= 0`, snapshot unchanged, `frame_drop` pulses for 1 cycle.
- **States.**
  - **IDLE:** `out_valid` = 0.
  - **DRAIN:** `out_valid` = 1.
    - `out_region` = index, `out_count` = `snap[index]`, `out_last` = (index == 5).
    - On `out_valid && out_ready`: index increments. If index was 5, go to IDLE.
- **Simultaneous events.** An accumulate pixel and frame end cannot coincide, because row 300 is outside every window. A transfer and frame end can coincide in the same DRAIN cycle: the transfer completes normally and the frame is still dropped.
- **Reset.** Asynchronous assertion at any time, including mid-DRAIN, forces:
  - state IDLE, index 0
  - `acc` = 0, `snap` = 0
  - `out_valid` = 0, `out_region` = 0, `out_count` = 0, `out_last` = 0, `frame_drop` = 0

## Timing

- Counts update at the `clk` edge that samples `pix_en`. Cycles without `pix_en` are ignored.
- Frame-end sampled at edge N: `out_valid` = 1 with region 0 after edge N.
- Each accepted entry advances at the accepting edge. Minimum drain time is 6 cycles with `out_ready` held high.
- `out_valid`, `out_region`, `out_count` and `out_last` are register outputs. They hold stable while `out_valid && !out_ready`.
- `out_valid` drops after the edge that accepts region 5.
- `frame_drop` is high for exactly the cycle after the dropping edge.

## Test plan

1. **Fully dark frame.** `pixel_in` = 12'h000 for the whole frame, `out_ready` = 1 → six entries, regions 0..5, each `out_count` = 11026, `out_last` only on region 5, no `frame_drop`.
2. **Threshold boundary.**
   - Window 2 fed 12'h888 (lum 24), all others 12'h777 (lum 21) → region 2 count 0, every other region 11026.
   - Repeat with `DARK_THRESH` = 25 → region 2 count 11026.
3. **Edges and off-window.**
   - Dark pixels only at hcnt 50, 51, 124, 125 on vcnt 151 → region 0 count 2.
   - Dark at vcnt 150 and 300 only → all counts 0.
   - Dark pixels without `pix_en` → not counted.
4. **Backpressure.** `out_ready` low 10 cycles after `out_valid` rises → region 0 entry held stable. Then toggle `out_ready` every cycle → entries emitted in order 0..5 with no loss or duplication.
5. **Overrun.** Hold `out_ready` = 0 through the next frame end → `frame_drop` pulses once and the snapshot still shows old values. The second frame's counts are discarded, and the third frame counts from 0.
6. **Reset mid-drain.** Assert `rst` after region 2 is accepted → all outputs 0 immediately. The next full frame then drains correctly starting from region 0.
